// File: rtl/sound_priority_arbiter.sv
// rtl/sound_priority_arbiter.sv - shares the tone generator between the music stream and three one-shot sound effects
module sound_priority_arbiter #(
  parameter int         STEP_CYCLES = 3125000,
  parameter int         GAP_CYCLES  = 1562500,
  parameter int         CW          = 22,
  parameter logic [4:0] REST_NOTE   = 5'd25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] music_note,
  input  logic [2:0] sfx_req,
  input  logic       mute,
  output logic [4:0] note_out,
  output logic       sfx_active,
  output logic [1:0] sfx_id,
  output logic       sfx_done
);

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  localparam logic [CW-1:0] STEP_LAST = CW'(STEP_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  state_t        state;
  logic [2:0]    pending;
  logic [1:0]    step;
  logic [CW-1:0] counter;

  logic [2:0]    req_all;
  logic          step_tc;
  logic          gap_tc;
  logic          last_tc;
  logic          do_start;
  logic [1:0]    start_id;

  function automatic logic [1:0] top_id(input logic [2:0] r);
    if (r[2])      return 2'd2;
    else if (r[1]) return 2'd1;
    else           return 2'd0;
  endfunction

  function automatic logic [4:0] seq_note(input logic [1:0] id, input logic [1:0] s);
    logic [4:0] n;
    n = REST_NOTE;
    case ({id, s})
      4'b00_00: n = 5'd12;
      4'b00_01: n = 5'd16;
      4'b00_10: n = 5'd19;
      4'b00_11: n = 5'd24;
      4'b01_00: n = 5'd9;
      4'b01_01: n = 5'd7;
      4'b01_10: n = 5'd5;
      4'b01_11: n = 5'd4;
      4'b10_00: n = 5'd12;
      4'b10_01: n = 5'd7;
      4'b10_10: n = 5'd4;
      4'b10_11: n = 5'd0;
      default:  n = REST_NOTE;
    endcase
    return n;
  endfunction

  function automatic logic [4:0] mute_gate(input logic m, input logic [4:0] n);
    return m ? REST_NOTE : n;
  endfunction

  assign req_all = pending | sfx_req;
  assign step_tc = (counter == STEP_LAST);
  assign gap_tc  = (counter == GAP_LAST);
  assign last_tc = (state == PLAY) && (step == 2'd3) && step_tc;

  // Completion of step 3 wins over a same-cycle request so the finished effect still reports done.
  always_comb begin
    do_start = 1'b0;
    start_id = top_id(req_all);
    case (state)
      IDLE, GAP: do_start = |req_all;
      PLAY: begin
        if (last_tc) begin
          do_start = |req_all;
        end else if (|sfx_req && (top_id(sfx_req) >= sfx_id)) begin
          do_start = 1'b1;
          start_id = top_id(sfx_req);
        end
      end
      default: do_start = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      note_out   <= REST_NOTE;
      pending    <= 3'b000;
      sfx_active <= 1'b0;
      sfx_id     <= 2'd0;
      sfx_done   <= 1'b0;
      step       <= 2'd0;
      counter    <= '0;
    end else begin
      sfx_done <= last_tc;
      if (do_start) begin
        state      <= PLAY;
        step       <= 2'd0;
        counter    <= '0;
        sfx_id     <= start_id;
        sfx_active <= 1'b1;
        pending    <= req_all & ~(3'b001 << start_id);
        note_out   <= mute_gate(mute, seq_note(start_id, 2'd0));
      end else begin
        pending <= req_all;
        case (state)
          IDLE: note_out <= mute_gate(mute, music_note);
          PLAY: begin
            if (last_tc) begin
              state      <= GAP;
              counter    <= '0;
              step       <= 2'd0;
              sfx_active <= 1'b0;
              note_out   <= mute_gate(mute, REST_NOTE);
            end else if (step_tc) begin
              counter  <= '0;
              step     <= step + 2'd1;
              note_out <= mute_gate(mute, seq_note(sfx_id, step + 2'd1));
            end else begin
              counter  <= counter + CNT_ONE;
              note_out <= mute_gate(mute, seq_note(sfx_id, step));
            end
          end
          GAP: begin
            // The edge that leaves the gap already loads music, so the rest lasts exactly GAP_CYCLES.
            if (gap_tc) begin
              state    <= IDLE;
              counter  <= '0;
              note_out <= mute_gate(mute, music_note);
            end else begin
              counter  <= counter + CNT_ONE;
              note_out <= mute_gate(mute, REST_NOTE);
            end
          end
          default: begin
            state    <= IDLE;
            note_out <= REST_NOTE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sound_priority_arbiter.sv
// tb/tb_sound_priority_arbiter.sv - randomized bench for sound_priority_arbiter against an elapsed-time reference model
module tb_sound_priority_arbiter;

  localparam int STEP = 4;
  localparam int GAP  = 2;
  localparam int REST = 25;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] music_note = 5'd0;
  logic [2:0] sfx_req = 3'b000;
  logic       mute = 1'b0;
  logic [4:0] note_out;
  logic       sfx_active;
  logic [1:0] sfx_id;
  logic       sfx_done;

  sound_priority_arbiter #(
    .STEP_CYCLES(STEP),
    .GAP_CYCLES (GAP),
    .CW         (4),
    .REST_NOTE  (5'd25)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .music_note(music_note),
    .sfx_req   (sfx_req),
    .mute      (mute),
    .note_out  (note_out),
    .sfx_active(sfx_active),
    .sfx_id    (sfx_id),
    .sfx_done  (sfx_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at t=%0t: got=%0d expected=%0d", tag, $time, got, exp);
    end
  endtask

  // Reference model: an effect is "elapsed cycles since start"; the note is the table entry for elapsed/STEP.
  int seq_tbl [0:2][0:3] = '{'{12, 16, 19, 24}, '{9, 7, 5, 4}, '{12, 7, 4, 0}};
  int   m_mode;      // 0 music, 1 effect, 2 gap
  int   m_id;
  int   m_elapsed;
  int   m_gap_elapsed;
  logic [2:0] m_pend;
  int   m_note;
  int   m_active;
  int   m_done;

  function automatic int highest(input logic [2:0] r);
    if (r[2]) return 2;
    if (r[1]) return 1;
    return 0;
  endfunction

  task automatic model_start(input int k, input logic [2:0] reqs);
    m_pend      = reqs;
    m_pend[k]   = 1'b0;
    m_mode      = 1;
    m_id        = k;
    m_elapsed   = 0;
    m_active    = 1;
    m_note      = seq_tbl[k][0];
  endtask

  task automatic model_edge();
    logic [2:0] reqs;
    if (reset) begin
      m_mode = 0; m_id = 0; m_elapsed = 0; m_gap_elapsed = 0;
      m_pend = 3'b000; m_note = REST; m_active = 0; m_done = 0;
      return;
    end
    reqs   = m_pend | sfx_req;
    m_done = 0;
    case (m_mode)
      0: begin
        if (reqs != 0) model_start(highest(reqs), reqs);
        else begin m_pend = reqs; m_note = music_note; end
      end
      1: begin
        if (m_elapsed == 4 * STEP - 1) begin
          m_done = 1;
          if (reqs != 0) model_start(highest(reqs), reqs);
          else begin
            m_pend = reqs; m_mode = 2; m_gap_elapsed = 0; m_active = 0; m_note = REST;
          end
        end else if (sfx_req != 0 && highest(sfx_req) >= m_id) begin
          model_start(highest(sfx_req), reqs);
        end else begin
          m_pend = reqs;
          m_elapsed++;
          m_note = seq_tbl[m_id][m_elapsed / STEP];
        end
      end
      default: begin
        if (reqs != 0) model_start(highest(reqs), reqs);
        else if (m_gap_elapsed == GAP - 1) begin
          m_pend = reqs; m_mode = 0; m_note = music_note;
        end else begin
          m_pend = reqs; m_gap_elapsed++; m_note = REST;
        end
      end
    endcase
    if (mute) m_note = REST;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("note_out",   note_out,   m_note);
    check("sfx_active", sfx_active, m_active);
    check("sfx_id",     sfx_id,     m_id);
    check("sfx_done",   sfx_done,   m_done);
  endtask

  task automatic pulse(input logic [2:0] r);
    sfx_req = r;
    tick();
    sfx_req = 3'b000;
  endtask

  int done_count;

  initial begin
    // Reset with music held, then music tracking
    reset = 1'b1; music_note = 5'd7;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    music_note = 5'd3;  tick();
    music_note = 5'd20; tick();
    music_note = 5'd7;  tick();

    // Single hit effect, gap, music
    pulse(3'b001);
    repeat (24) tick();

    // Game over preempts hit at step 1
    pulse(3'b001);
    repeat (5) tick();
    pulse(3'b100);
    repeat (24) tick();

    // Lower request during game over stays pending and follows back-to-back
    pulse(3'b100);
    repeat (6) tick();
    pulse(3'b001);
    repeat (40) tick();

    // Two simultaneous requests: miss then hit, done pulses counted
    done_count = 0;
    pulse(3'b011);
    repeat (40) begin
      tick();
      if (sfx_done) done_count++;
    end
    check("done_pulses_011", done_count, 2);

    // Mute during miss, then reset at step 2
    pulse(3'b010);
    mute = 1'b1;
    repeat (9) tick();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0; mute = 1'b0;
    repeat (5) tick();

    // Randomized traffic
    repeat (3000) begin
      music_note = 5'($urandom_range(0, 25));
      sfx_req    = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      if ($urandom_range(0, 19) == 0) mute = ~mute;
      reset      = ($urandom_range(0, 299) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sound_priority_arbiter.md
Name: sound_priority_arbiter

Overview:
- Shares the single note/tone generator between the in-game background music stream and three one-shot sound effects (SFX): hit, miss and game over.
- Sits between the music FSM note output and the tone generator input.
- Passes music through when idle.
- On a request, substitutes a fixed 4-step SFX note sequence, then a short rest gap, then returns to music.
- Priority and pending logic decide which effect plays.

Parameters:
- STEP_CYCLES, 3125000, clock cycles per SFX step (62.5 ms at 50 MHz).
- GAP_CYCLES, 1562500, rest cycles between the end of an SFX and the return to music.
- CW, 22, width of the step/gap counters; must hold max(STEP_CYCLES, GAP_CYCLES).
- REST_NOTE, 25, note code meaning silence.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- music_note  input  5  current note code from the music FSM (0-24 pitch, 25 rest)
- sfx_req  input  3  request pulses; bit0 hit, bit1 miss, bit2 game over
- mute  input  1  forces note_out to REST_NOTE; all sequencing continues unchanged
- note_out  output  5  registered note code to the tone generator
- sfx_active  output  1  high while an SFX step is playing
- sfx_id  output  2  id of the effect playing or last played
- sfx_done  output  1  one-cycle pulse when an SFX completes all 4 steps (never on preemption)

Behaviour:
- Clocking and reset:
  - One clock: clk.
  - Reset is synchronous and active-high on reset.
  - At a reset edge: state IDLE, note_out=REST_NOTE, pending=000, sfx_active=0, sfx_id=0, sfx_done=0, step=0, counter=0.
  - Reset mid-SFX aborts the effect with no sfx_done pulse.
- State machine: IDLE, PLAY, GAP.
- Sequences (steps 0..3):
  - id0: 12, 16, 19, 24
  - id1: 9, 7, 5, 4
  - id2: 12, 7, 4, 0
- Priority: id2 > id1 > id0.
- All requests OR into pending[2:0] at each edge.
- Start of an effect:
  - Starting id k clears pending[k].
  - It sets state=PLAY, step=0, counter=0, sfx_id=k, sfx_active=1.
  - note_out <= seq[k][0] at that same edge, so the effect is visible the cycle after the request edge.
- IDLE:
  - note_out <= music_note each cycle (1-cycle latency).
  - If any request or pending bit is set, start the highest one.
- PLAY:
  - counter counts 0..STEP_CYCLES-1 within a step.
  - At terminal count, step increments and note_out <= seq[id][step+1].
  - Each step holds exactly STEP_CYCLES cycles.
  - At terminal count of step 3: sfx_done pulses for one cycle.
  - If any bit is pending at that point (including requests arriving that cycle), start the highest pending effect directly, with no gap.
  - Otherwise go to GAP with note_out <= REST_NOTE and sfx_active=0.
- Requests during PLAY:
  - Strictly higher id than current: preempt at that edge. The new effect starts from step 0; the old effect is discarded (not set pending, no sfx_done).
  - Same id: restart at step 0.
  - Lower id: set pending only.
  - Several bits in one cycle: the highest acts as above; the rest become pending.
- GAP:
  - note_out=REST_NOTE for GAP_CYCLES cycles, then IDLE.
  - The first IDLE edge loads music_note.
  - Any request arriving in GAP starts immediately.
- mute:
  - note_out is REST_NOTE on every cycle mute was high at the preceding edge.
  - State, counters, pending and sfx_done are unaffected.
- sfx_id retains its value in IDLE/GAP.
- Counters never wrap: every terminal count resets the counter to 0.

Test Plan:
- Bench parameters: STEP_CYCLES=4, GAP_CYCLES=2.
- Reset then music_note=7 held, no requests -> note_out=25 during reset; one cycle after release, note_out=7 and tracks music_note with 1-cycle latency; sfx_active=0.
- sfx_req=001 pulse in IDLE -> note_out 12,16,19,24 for 4 cycles each; sfx_done pulses on the last step-3 cycle; note_out=25 for 2 cycles; then music resumes.
- Play id0; at step 1 pulse sfx_req=100 -> id2 sequence 12,7,4,0 starts next edge; sfx_id=2; no sfx_done for id0; after id2 completes, sfx_done once, gap, music.
- Play id2; pulse sfx_req=001 mid-effect -> id2 finishes uninterrupted; sfx_done pulses; id0 starts immediately (no rest gap).
- sfx_req=011 in IDLE -> id1 plays first, then id0 back-to-back; two sfx_done pulses 16 cycles apart.
- Assert mute during an id1 playback, then reset at step 2 -> note_out=25 throughout mute while step timing continues; at reset, state IDLE, pending=0, no sfx_done.
